// File: rtl/lspc_vram_cpu_port.sv
`default_nettype none
// ============================================================================
//  Module   : lspc_vram_cpu_port
//  Purpose  : CPU-side initiator for LSPC VRAM accesses. Holds VRAMADDR,
//             VRAMRW and VRAMMOD, issues write requests and prefetch reads
//             toward the fast/slow VRAM cycle logic, and steps the address
//             by the signed modulo after each completed write.
//  Revision : 1.0 - initial release
// ============================================================================
module lspc_vram_cpu_port (
  input  logic        CLK_24M,
  input  logic        RESETP,
  input  logic        CPU_WR_STB,
  input  logic        CPU_RD_STB,
  input  logic [1:0]  CPU_REG_SEL,
  input  logic [15:0] CPU_DATA_IN,
  output logic [15:0] CPU_DATA_OUT,
  output logic        CPU_BUSY,
  output logic        OVERRUN,
  output logic        nVRAM_WRITE_REQ,
  output logic [15:0] VRAM_ADDR,
  output logic [15:0] VRAM_WRITE,
  output logic        REG_VRAMADDR_MSB,
  input  logic        VRAM_WR_ACK,
  output logic        VRAM_RD_REQ,
  input  logic        VRAM_RD_ACK,
  input  logic [15:0] VRAM_RD_DATA
);

  localparam logic [1:0] SEL_ADDR = 2'd0;
  localparam logic [1:0] SEL_RW   = 2'd1;
  localparam logic [1:0] SEL_MOD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_PEND = 2'd1,
    ST_RD_PEND = 2'd2
  } state_t;

  state_t      state, state_nx;

  logic [15:0] addr, addr_nx;
  logic [15:0] mod, mod_nx;
  logic [15:0] prefetch, prefetch_nx;
  logic [15:0] wdata, wdata_nx;
  logic [1:0]  slot_sel, slot_sel_nx;
  logic [15:0] slot_data, slot_data_nx;
  logic        slot_full, slot_full_nx;
  logic        overrun, overrun_nx;

  // Command being executed this cycle (only meaningful in IDLE).
  logic        cmd_valid;
  logic [1:0]  cmd_sel;
  logic [15:0] cmd_data;

  // This port exposes no prefetch-consumed flag, so the read strobe is
  // accepted and deliberately left without effect.
  logic unused_rd_stb;
  assign unused_rd_stb = CPU_RD_STB;

  // State and register file update; reset discards all pending work.
  always_ff @(posedge CLK_24M) begin
    if (!RESETP) begin
      state     <= ST_IDLE;
      addr      <= 16'h0000;
      mod       <= 16'h0000;
      prefetch  <= 16'h0000;
      wdata     <= 16'h0000;
      slot_sel  <= 2'd0;
      slot_data <= 16'h0000;
      slot_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      mod       <= mod_nx;
      prefetch  <= prefetch_nx;
      wdata     <= wdata_nx;
      slot_sel  <= slot_sel_nx;
      slot_data <= slot_data_nx;
      slot_full <= slot_full_nx;
      overrun   <= overrun_nx;
    end
  end

  // Next-state: command dispatch in IDLE, ack handling in the pending
  // states, and holding-slot capture of strobes that cannot run now.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    mod_nx       = mod;
    prefetch_nx  = prefetch;
    wdata_nx     = wdata;
    slot_sel_nx  = slot_sel;
    slot_data_nx = slot_data;
    slot_full_nx = slot_full;
    overrun_nx   = overrun;
    cmd_valid    = 1'b0;
    cmd_sel      = slot_sel;
    cmd_data     = slot_data;

    case (state)
      ST_IDLE: begin
        if (slot_full) begin
          // Drain the slot first; a strobe arriving now refills it so
          // ordering between buffered and fresh writes is preserved.
          cmd_valid    = 1'b1;
          slot_full_nx = 1'b0;
          if (CPU_WR_STB) begin
            slot_sel_nx  = CPU_REG_SEL;
            slot_data_nx = CPU_DATA_IN;
            slot_full_nx = 1'b1;
          end
        end else if (CPU_WR_STB) begin
          cmd_valid = 1'b1;
          cmd_sel   = CPU_REG_SEL;
          cmd_data  = CPU_DATA_IN;
        end

        if (cmd_valid) begin
          case (cmd_sel)
            SEL_ADDR: begin
              addr_nx  = cmd_data;
              state_nx = ST_RD_PEND;
            end
            SEL_RW: begin
              wdata_nx = cmd_data;
              state_nx = ST_WR_PEND;
            end
            SEL_MOD: begin
              mod_nx = cmd_data;
            end
            default: begin
            end
          endcase
        end
      end

      ST_WR_PEND: begin
        if (VRAM_WR_ACK) begin
          // Modulo is two's complement; plain 16-bit addition wraps.
          addr_nx  = addr + mod;
          state_nx = ST_RD_PEND;
        end
      end

      ST_RD_PEND: begin
        if (VRAM_RD_ACK) begin
          prefetch_nx = VRAM_RD_DATA;
          state_nx    = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Strobes while busy go to the slot; with the slot occupied they are lost.
    if ((state != ST_IDLE) && CPU_WR_STB) begin
      if (!slot_full) begin
        slot_sel_nx  = CPU_REG_SEL;
        slot_data_nx = CPU_DATA_IN;
        slot_full_nx = 1'b1;
      end else begin
        overrun_nx = 1'b1;
      end
    end
  end

  // Register readback; never stalls.
  always_comb begin
    case (CPU_REG_SEL)
      SEL_ADDR, SEL_RW: CPU_DATA_OUT = prefetch;
      SEL_MOD:          CPU_DATA_OUT = mod;
      default:          CPU_DATA_OUT = 16'h0000;
    endcase
  end

  assign nVRAM_WRITE_REQ  = (state != ST_WR_PEND);
  assign VRAM_RD_REQ      = (state == ST_RD_PEND);
  assign VRAM_ADDR        = addr;
  assign VRAM_WRITE       = wdata;
  assign REG_VRAMADDR_MSB = addr[15];
  assign CPU_BUSY         = (state != ST_IDLE) || slot_full;
  assign OVERRUN          = overrun;

endmodule
`default_nettype wire
